// File: rtl/mem_block_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_mover_pkg
// Description : Shared types for the data-memory block mover: FSM state,
//               transfer mode and pointer direction encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_block_mover_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [0:0] {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_t;

    typedef enum logic [0:0] {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/mem_block_mover_addr_stepper.sv
`default_nettype none
// ============================================================================
// Module      : addr_stepper
// Description : Loadable AW-bit address pointer. Load has priority over step;
//               a step moves the pointer by one, up or down, wrapping mod 2^AW.
// Ports       : Clk, Reset      - clock, synchronous active-high reset
//               i_load, i_load_val - load strobe and value
//               i_step, i_down  - step enable, 1 = decrement
//               o_ptr           - current pointer
// Revision    : 1.0 - initial release
// ============================================================================
module addr_stepper #(
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    input  logic          i_step,
    input  logic          i_down,
    output logic [AW-1:0] o_ptr
);

    localparam logic [AW-1:0] C_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] r_ptr_q;
    logic [AW-1:0] w_ptr_d;

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (i_load) begin
            w_ptr_d = i_load_val;
        end else if (i_step) begin
            w_ptr_d = i_down ? (r_ptr_q - C_ONE) : (r_ptr_q + C_ONE);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_ptr = r_ptr_q;

endmodule
`default_nettype wire

// File: rtl/mem_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_mover
// Description : Bus-master engine for the single-port data memory performing
//               block copy (READ/WRITE pairs) or block fill (WRITE only).
// Ports       : Clk, Reset       - clock, synchronous active-high reset
//               Start, Mode, Src, Dst, Len, FillVal - request, sampled in IDLE
//               Busy, Done        - status (Done is a one-cycle pulse)
//               MemAddr, MemWriteEn, MemDataIn - memory command outputs
//               MemDataOut        - combinational memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] Src,
    input  logic [AW-1:0] Dst,
    input  logic [AW-1:0] Len,
    input  logic [DW-1:0] FillVal,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] MemAddr,
    output logic          MemWriteEn,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut
);

    localparam logic [AW-1:0] C_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state_q, w_state_d;
    mode_t         r_mode_q,  w_mode_d;
    dir_t          r_dir_q,   w_dir_d;
    logic [AW-1:0] r_count_q, w_count_d;
    logic [DW-1:0] r_buf_q,   w_buf_d;
    logic [DW-1:0] r_fill_q,  w_fill_d;

    logic          w_load;
    logic          w_step;
    logic          w_backward;
    logic [AW-1:0] w_diff;
    logic [AW-1:0] w_src_start;
    logic [AW-1:0] w_dst_start;
    logic [AW-1:0] w_src_ptr;
    logic [AW-1:0] w_dst_ptr;

    // Walk backward only when a forward copy would overwrite source bytes
    // before they are read (destination starts inside the source range).
    assign w_diff      = Dst - Src;
    assign w_backward  = (Mode == MODE_COPY) && (Dst > Src) && (w_diff < Len);
    assign w_src_start = w_backward ? (Src + Len - C_ONE) : Src;
    assign w_dst_start = w_backward ? (Dst + Len - C_ONE) : Dst;

    always_comb begin
        w_state_d = r_state_q;
        w_mode_d  = r_mode_q;
        w_dir_d   = r_dir_q;
        w_count_d = r_count_q;
        w_buf_d   = r_buf_q;
        w_fill_d  = r_fill_q;
        w_load    = 1'b0;
        w_step    = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (Start) begin
                    w_load    = 1'b1;
                    w_mode_d  = mode_t'(Mode);
                    w_dir_d   = w_backward ? DIR_BWD : DIR_FWD;
                    w_count_d = Len;
                    w_fill_d  = FillVal;
                    if (Len == '0) begin
                        w_state_d = DONE;
                    end else if (Mode == MODE_FILL) begin
                        w_state_d = WRITE;
                    end else begin
                        w_state_d = READ;
                    end
                end
            end
            READ: begin
                w_buf_d   = MemDataOut;
                w_state_d = WRITE;
            end
            WRITE: begin
                w_step    = 1'b1;
                w_count_d = r_count_q - C_ONE;
                if (r_count_q == C_ONE) begin
                    w_state_d = DONE;
                end else if (r_mode_q == MODE_COPY) begin
                    w_state_d = READ;
                end else begin
                    w_state_d = WRITE;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q <= IDLE;
            r_mode_q  <= MODE_COPY;
            r_dir_q   <= DIR_FWD;
            r_count_q <= '0;
            r_buf_q   <= '0;
            r_fill_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_mode_q  <= w_mode_d;
            r_dir_q   <= w_dir_d;
            r_count_q <= w_count_d;
            r_buf_q   <= w_buf_d;
            r_fill_q  <= w_fill_d;
        end
    end

    // Source pointer only moves on WRITE, so after a READ it still addresses
    // the byte just captured; both pointers advance together.
    addr_stepper #(.AW(AW)) u_src_ptr (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_load),
        .i_load_val (w_src_start),
        .i_step     (w_step),
        .i_down     (r_dir_q == DIR_BWD),
        .o_ptr      (w_src_ptr)
    );

    addr_stepper #(.AW(AW)) u_dst_ptr (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_load),
        .i_load_val (w_dst_start),
        .i_step     (w_step),
        .i_down     (r_dir_q == DIR_BWD),
        .o_ptr      (w_dst_ptr)
    );

    // Outputs decode registered state and pointers only.
    assign Busy       = (r_state_q != IDLE);
    assign Done       = (r_state_q == DONE);
    assign MemWriteEn = (r_state_q == WRITE);
    assign MemAddr    = (r_state_q == READ)  ? w_src_ptr :
                        (r_state_q == WRITE) ? w_dst_ptr : '0;
    assign MemDataIn  = (r_state_q != WRITE)      ? '0 :
                        (r_mode_q == MODE_FILL)   ? r_fill_q : r_buf_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_mover
// Description : Self-checking bench for mem_block_mover with a 256-byte
//               memory model and a byte-order reference model of transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_mover;

    localparam int C_LIMIT = 700;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Mode = 1'b0;
    logic [7:0] Src = '0, Dst = '0, Len = '0, FillVal = '0;
    logic       Busy, Done, MemWriteEn;
    logic [7:0] MemAddr, MemDataIn, MemDataOut;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0, tb_data = '0;

    int checks = 0;
    int errors = 0;

    int obs_done_cyc, obs_done_cnt, obs_idle_cyc, obs_writes, obs_busy;
    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemWriteEn) mem[MemAddr] <= MemDataIn;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end
    assign MemDataOut = mem[MemAddr];

    mem_block_mover #(.AW(8), .DW(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Src(Src),
        .Dst(Dst), .Len(Len), .FillVal(FillVal), .Busy(Busy), .Done(Done),
        .MemAddr(MemAddr), .MemWriteEn(MemWriteEn), .MemDataIn(MemDataIn),
        .MemDataOut(MemDataOut)
    );

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge Clk); #1;
        tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference: apply the transfer byte by byte in the order the rules
    // prescribe, recording the expected {write, address} access stream.
    task automatic model_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] n, input logic [7:0] f, input int max_bytes);
        bit back;
        logic [7:0] off, sa, da;
        exp_q.delete();
        back = (m == 1'b0) && (d > s) && (8'(d - s) < n);
        for (int k = 0; k < int'(n) && k < max_bytes; k++) begin
            off = back ? 8'(int'(n) - 1 - k) : 8'(k);
            sa = s + off;
            da = d + off;
            if (m == 1'b0) begin
                exp_q.push_back({1'b0, sa});
                exp_q.push_back({1'b1, da});
                ref_mem[da] = ref_mem[sa];
            end else begin
                exp_q.push_back({1'b1, da});
                ref_mem[da] = f;
            end
        end
    endtask

    function automatic int exp_done(input logic m, input logic [7:0] n);
        if (n == 0) return 1;
        return (m == 1'b0) ? 2 * int'(n) + 1 : int'(n) + 1;
    endfunction

    // Drives one transfer and records what the DUT does until Busy falls.
    task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] n, input logic [7:0] f,
                            input int pulse_at, input int reset_at);
        obs_done_cyc = -1; obs_done_cnt = 0; obs_idle_cyc = -1;
        obs_writes = 0; obs_busy = 0;
        obs_q.delete();
        @(negedge Clk);
        Start = 1'b1; Mode = m; Src = s; Dst = d; Len = n; FillVal = f;
        for (int cyc = 1; cyc <= C_LIMIT; cyc++) begin
            @(negedge Clk);
            Start = (cyc == pulse_at);
            if (Start) begin
                Mode = ~m; Src = 8'($urandom); Dst = 8'($urandom); Len = 8'd5;
                FillVal = 8'($urandom);
            end
            if (cyc == reset_at) Reset = 1'b1;
            if (Busy) obs_busy++;
            if (MemWriteEn) obs_writes++;
            if (Busy && !Done) obs_q.push_back({MemWriteEn, MemAddr});
            if (Done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
            end
            if (!Busy) begin
                obs_idle_cyc = cyc;
                break;
            end
        end
        Start = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Busy, Done, MemWriteEn, MemAddr, MemDataIn} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b we=%0b addr=%h data=%h, want all 0",
                     Busy, Done, MemWriteEn, MemAddr, MemDataIn);
        end
        Reset = 1'b0;
        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
    endtask

    task automatic test_copy_basic;
        for (int i = 0; i < 16; i++) poke(8'(8'h10 + i), 8'(i));
        model_xfer(1'b0, 8'h10, 8'h40, 8'd16, 8'h00, 999);
        run_xfer(1'b0, 8'h10, 8'h40, 8'd16, 8'h00, 0, 0);
        checks++;
        if (obs_done_cyc !== 33 || obs_done_cnt !== 1) begin
            errors++;
            $display("FAIL copy_done: got cycle %0d count %0d, want cycle 33 count 1", obs_done_cyc, obs_done_cnt);
        end
        checks++;
        if (obs_busy !== 33 || obs_idle_cyc !== 34) begin
            errors++;
            $display("FAIL copy_busy: got %0d busy cycles idle at %0d, want 33 idle at 34", obs_busy, obs_idle_cyc);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[8'h40 + i] !== 8'(i)) begin
                errors++;
                $display("FAIL copy_byte[%0d]: got %h want %h", i, mem[8'h40 + i], 8'(i));
            end
        end
        checks++;
        if (obs_q != exp_q) begin
            errors++;
            $display("FAIL copy_access_order: got %0d accesses, want %0d in model order", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_fill;
        model_xfer(1'b1, 8'h80, 8'h80, 8'd4, 8'hA5, 999);
        run_xfer(1'b1, 8'h00, 8'h80, 8'd4, 8'hA5, 0, 0);
        checks++;
        if (obs_done_cyc !== 5 || obs_writes !== 4) begin
            errors++;
            $display("FAIL fill_done: got cycle %0d writes %0d, want cycle 5 writes 4", obs_done_cyc, obs_writes);
        end
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++;
                $display("FAIL fill_mem[%h]: got %h want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_overlap;
        for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), 8'(i + 1));
        model_xfer(1'b0, 8'h20, 8'h22, 8'd4, 8'h00, 999);
        run_xfer(1'b0, 8'h20, 8'h22, 8'd4, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[8'h22 + i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL overlap_byte[%0d]: got %h want %h", i, mem[8'h22 + i], 8'(i + 1));
            end
        end
        checks++;
        if (obs_q.size() < 2 || obs_q[0] !== 9'h023 || obs_q[1] !== 9'h125) begin
            errors++;
            $display("FAIL overlap_first_access: got %0d entries, want read 23 then write 25", obs_q.size());
        end
        checks++;
        if (obs_q != exp_q || obs_done_cyc !== 9) begin
            errors++;
            $display("FAIL overlap_order: got done %0d, %0d accesses, want done 9 in model order", obs_done_cyc, obs_q.size());
        end
    endtask

    task automatic test_wrap;
        model_xfer(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 999);
        run_xfer(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 0, 0);
        checks++;
        if (mem[8'hFE] !== 8'h5A || mem[8'hFF] !== 8'h5A || mem[8'h00] !== 8'h5A || mem[8'h01] !== ref_mem[8'h01]) begin
            errors++;
            $display("FAIL wrap_mem: got FE=%h FF=%h 00=%h 01=%h, want 5A 5A 5A %h",
                     mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], ref_mem[8'h01]);
        end
        checks++;
        if (obs_q != exp_q) begin
            errors++;
            $display("FAIL wrap_order: got %0d accesses, want %0d in model order", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_len0_and_busy_start;
        run_xfer(1'b0, 8'h30, 8'h50, 8'd0, 8'h00, 0, 0);
        checks++;
        if (obs_done_cyc !== 1 || obs_writes !== 0 || obs_idle_cyc !== 2) begin
            errors++;
            $display("FAIL len0: got done %0d writes %0d idle %0d, want 1 0 2", obs_done_cyc, obs_writes, obs_idle_cyc);
        end
        model_xfer(1'b1, 8'h00, 8'hC0, 8'd6, 8'h3C, 999);
        run_xfer(1'b1, 8'h00, 8'hC0, 8'd6, 8'h3C, 3, 0);
        @(negedge Clk);
        checks++;
        if (obs_done_cnt !== 1 || obs_done_cyc !== 7 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: got dones %0d at %0d busy_after=%0b, want 1 at 7 busy 0",
                     obs_done_cnt, obs_done_cyc, Busy);
        end
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++;
                $display("FAIL busy_start_mem[%h]: got %h want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset_mid;
        model_xfer(1'b0, 8'h60, 8'h90, 8'd8, 8'h00, 2);
        run_xfer(1'b0, 8'h60, 8'h90, 8'd8, 8'h00, 0, 4);
        checks++;
        if (obs_done_cnt !== 0 || obs_idle_cyc !== 5 || obs_writes !== 2) begin
            errors++;
            $display("FAIL reset_mid: got dones %0d idle %0d writes %0d, want 0 5 2",
                     obs_done_cnt, obs_idle_cyc, obs_writes);
        end
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++;
                $display("FAIL reset_mid_mem[%h]: got %h want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_random;
        logic m;
        logic [7:0] s, d, n, f;
        int pulse;
        for (int it = 0; it < 12; it++) begin
            m = 1'($urandom);
            s = 8'($urandom);
            d = (it % 3 == 0) ? 8'(s + $urandom_range(6, 0)) : 8'($urandom);
            n = 8'($urandom_range(24, 0));
            f = 8'($urandom);
            pulse = (n >= 3) ? 2 : 0;
            model_xfer(m, s, d, n, f, 999);
            run_xfer(m, s, d, n, f, pulse, 0);
            checks++;
            if (obs_done_cyc !== exp_done(m, n) || obs_done_cnt !== 1 || obs_idle_cyc !== exp_done(m, n) + 1) begin
                errors++;
                $display("FAIL rand%0d_timing: got done %0d x%0d idle %0d, want done %0d x1 idle %0d",
                         it, obs_done_cyc, obs_done_cnt, obs_idle_cyc, exp_done(m, n), exp_done(m, n) + 1);
            end
            checks++;
            if (obs_q != exp_q || obs_writes !== int'(n)) begin
                errors++;
                $display("FAIL rand%0d_access: got %0d accesses %0d writes, want %0d accesses %0d writes",
                         it, obs_q.size(), obs_writes, exp_q.size(), n);
            end
            for (int a = 0; a < 256; a++) begin
                checks++;
                if (mem[a] !== ref_mem[a]) begin
                    errors++;
                    $display("FAIL rand%0d_mem[%h]: got %h want %h", it, a, mem[a], ref_mem[a]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy_basic();
        test_fill();
        test_overlap();
        test_wrap();
        test_len0_and_busy_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_block_mover.md
# mem_block_mover

Bus-master engine that drives the 256-byte single-port data memory (8-bit address, combinational read, synchronous write) to perform block copy or block fill without core involvement. It is the initiator side of the data-memory port: it generates address, write-enable and write data, and samples read data. The core starts a transfer with a one-cycle pulse, stalls on Busy, and resumes on Done; the top level muxes the memory port to this block while Busy is high.

## Interface
Parameters:
- AW, 8, memory address width (memory depth 2^AW, all pointer arithmetic mod 2^AW)
- DW, 8, memory data width

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; returns block to IDLE
- Start  in  1  one-cycle request; sampled only in IDLE
- Mode  in  1  0 = copy, 1 = fill; sampled with Start
- Src  in  AW  copy source base address; sampled with Start
- Dst  in  AW  destination base address; sampled with Start
- Len  in  AW  byte count, 0 = no-op; sampled with Start
- FillVal  in  DW  fill byte; sampled with Start
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse when transfer completes
- MemAddr  out  AW  address to data memory
- MemWriteEn  out  1  write strobe to data memory
- MemDataIn  out  DW  write data to data memory
- MemDataOut  in  DW  combinational read data from data memory

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: Start=1 latches Mode, Src, Dst, Len, FillVal, computes direction; next = DONE if Len==0, else WRITE if fill, else READ. Start=0 stays IDLE.
- Direction: backward iff copy and Dst>Src (unsigned) and (Dst−Src)<Len; else forward. Forward pointers start at Src/Dst and increment; backward pointers start at Src+Len−1 / Dst+Len−1 (mod 2^AW) and decrement.
- READ (copy only): MemAddr=src_ptr, MemWriteEn=0; MemDataOut captured into byte buffer at edge; next WRITE.
- WRITE: MemAddr=dst_ptr, MemWriteEn=1, MemDataIn = buffer (copy) or FillVal (fill). At edge: step both pointers, decrement remaining count; if remaining was 1, next DONE; else next READ (copy) or WRITE (fill).
- DONE: Done=1 for exactly one cycle, next IDLE.
- Pointer overflow wraps mod 2^AW (e.g. Dst=0xFF, Len=2 forward writes 0xFF then 0x00).
- Start while Busy is ignored; no queuing.
- Reset mid-transfer: IDLE after the reset edge; bytes already written stay written; no Done pulse.

## Timing
- Reset values: Busy=0, Done=0, MemWriteEn=0, MemAddr=0, MemDataIn=0; internal pointers, count, buffer cleared.
- Outputs decoded from registered state/pointers only; no combinational path from Start or MemDataOut to any output.
- Start at edge 0: copy of N bytes occupies cycles 1..2N (odd=READ, even=WRITE), Done high in cycle 2N+1; fill of N bytes writes in cycles 1..N, Done in N+1; Len=0 gives Done in cycle 1 with no writes.
- Busy rises the cycle after Start edge, falls the cycle after Done.
- MemWriteEn high only in WRITE; never two consecutive memory accesses to the same address unless a same-address copy (Src==Dst).
- Max transfer Len=255 bytes.

## Structure
- Package mem_block_mover_pkg: state enum (IDLE, READ, WRITE, DONE), mode enum (MODE_COPY, MODE_FILL), direction enum.
- One sub-module, addr_stepper: loadable AW-bit pointer with step enable and up/down select, instantiated twice (src, dst).
- Byte counter and buffer live in the top module.

## Test plan
- Reset then memory preloaded 0x00..0x0F at 0x10..0x1F; copy Src=0x10 Dst=0x40 Len=16 -> 0x40..0x4F = 0x00..0x0F, Done exactly in cycle 33, Busy 32+1 cycles.
- Fill Dst=0x80 Len=4 FillVal=0xA5 -> 0x80..0x83 = 0xA5, 0x84 untouched, Done in cycle 5.
- Overlap: 0x20..0x23 = 1,2,3,4; copy Src=0x20 Dst=0x22 Len=4 -> 0x22..0x25 = 1,2,3,4 (backward order observed on MemAddr: 0x23,0x25,...).
- Wrap: fill Dst=0xFE Len=3 FillVal=0x5A -> 0xFE, 0xFF, 0x00 written; 0x01 untouched.
- Len=0 copy -> no MemWriteEn, Done in cycle 1; Start pulsed during Busy -> ignored, single Done.
- Reset asserted mid-copy after 2 bytes written -> IDLE next cycle, Busy=0, no Done, first 2 destination bytes updated, remainder unchanged.
